ttt_game_ctrl: RTL

//  Game sequencer for the 3x3 board. Takes one-cycle move pulses carrying a cell index 0..8.

---
 rtl/ttt_game_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the X/O board masks, alternates turns,
// enforces a per-turn timeout and reports win/draw with a highlight mask.
module ttt_game_ctrl #(
    parameter int unsigned TURN_CYCLES = 50_000_000,
    localparam int unsigned TW = (TURN_CYCLES == 0) ? 1 : $clog2(TURN_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          move_valid,
    input  logic [3:0]    move_pos,
    output logic          move_ready,
    output logic          move_err,
    output logic [8:0]    cell_x,
    output logic [8:0]    cell_o,
    output logic          turn_o,
    output logic          game_over,
    output logic [1:0]    winner,
    output logic [8:0]    win_mask,
    output logic [TW-1:0] time_left
);

    typedef enum logic [1:0] {IDLE, TURN, CHECK, DONE} state_t;

    localparam bit          TMO_EN  = (TURN_CYCLES != 0);
    localparam logic [TW-1:0] TL_LOAD = TW'((TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1);

    // rows, columns, diagonals (bit i = cell i)
    localparam logic [7:0][8:0] LINES = {
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    state_t          state, state_nxt;
    logic [8:0]      cell_x_nxt, cell_o_nxt, win_mask_nxt;
    logic            turn_o_nxt, move_err_nxt;
    logic [1:0]      winner_nxt;
    logic [TW-1:0]   time_left_nxt;

    logic [8:0]      occ;
    logic [15:0]     occ_pad;
    logic            legal, illegal, timeout;
    logic [3:0]      free_idx;
    logic [8:0]      place_bit;
    logic [8:0]      mover, hits;

    assign occ = cell_x | cell_o;
    // positions 9..15 read as permanently occupied, so one lookup covers both illegal cases
    assign occ_pad = {7'h7F, occ};
    assign legal   = move_valid && !occ_pad[move_pos];
    assign illegal = move_valid && occ_pad[move_pos];
    assign timeout = TMO_EN && (time_left == '0);

    always_comb begin
        free_idx = '0;
        for (int unsigned i = 9; i > 0; i--) begin
            if (!occ[i-1]) free_idx = 4'(i - 1);
        end
    end

    assign place_bit = 9'(1) << (legal ? move_pos : free_idx);

    always_comb begin
        mover = turn_o ? cell_o : cell_x;
        hits  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((mover & LINES[i]) == LINES[i]) hits = hits | LINES[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cell_x    <= '0;
            cell_o    <= '0;
            turn_o    <= 1'b0;
            winner    <= '0;
            win_mask  <= '0;
            time_left <= '0;
            move_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cell_x    <= cell_x_nxt;
            cell_o    <= cell_o_nxt;
            turn_o    <= turn_o_nxt;
            winner    <= winner_nxt;
            win_mask  <= win_mask_nxt;
            time_left <= time_left_nxt;
            move_err  <= move_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cell_x_nxt    = cell_x;
        cell_o_nxt    = cell_o;
        turn_o_nxt    = turn_o;
        winner_nxt    = winner;
        win_mask_nxt  = win_mask;
        time_left_nxt = time_left;
        move_err_nxt  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = TURN;
                    cell_x_nxt    = '0;
                    cell_o_nxt    = '0;
                    turn_o_nxt    = 1'b0;
                    winner_nxt    = '0;
                    win_mask_nxt  = '0;
                    time_left_nxt = TL_LOAD;
                end
            end
            TURN: begin
                move_err_nxt  = illegal;
                time_left_nxt = (time_left == '0) ? '0 : time_left - TW'(1);
                // a legal move takes priority over a simultaneous timeout
                if (legal || timeout) begin
                    if (turn_o) cell_o_nxt = cell_o | place_bit;
                    else        cell_x_nxt = cell_x | place_bit;
                    state_nxt     = CHECK;
                    time_left_nxt = '0;
                end
            end
            CHECK: begin
                if (hits != '0) begin
                    winner_nxt   = turn_o ? 2'b10 : 2'b01;
                    win_mask_nxt = hits;
                    state_nxt    = DONE;
                end else if (occ == 9'h1FF) begin
                    winner_nxt   = 2'b00;
                    win_mask_nxt = '0;
                    state_nxt    = DONE;
                end else begin
                    turn_o_nxt    = !turn_o;
                    time_left_nxt = TL_LOAD;
                    state_nxt     = TURN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign move_ready = (state == TURN);
    assign game_over  = (state == DONE);

endmodule
